// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: valid/ready pipeline register between two pipeline stages.
// SKID=0 gives a single-entry register whose in_ready is combinational from
// out_ready. SKID=1 adds a second (skid) entry so in_ready can be registered,
// breaking the ready path between stages. Bubbles always present all-zero
// control so a stalled or empty stage never asserts RegWrite/MemWrite.
module pipe_skid_reg #(
    parameter int PAYLOAD_W = 101,
    parameter int CTRL_W    = 7,
    parameter int SKID      = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic [CTRL_W-1:0]    in_ctrl,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [CTRL_W-1:0]    out_ctrl,
    output logic [1:0]           count
);

    // Head entry: the one currently presented downstream.
    logic                 head_valid;
    logic [PAYLOAD_W-1:0] head_payload;
    logic [CTRL_W-1:0]    head_ctrl;

    assign out_valid   = head_valid;
    assign out_payload = head_payload;
    assign out_ctrl    = head_valid ? head_ctrl : '0;

    generate
        if (SKID != 0) begin : g_skid
            // Skid entry only ever holds data while the head is stalled, so
            // skid_valid implies head_valid. ready_q mirrors !skid_valid but
            // as its own flop, keeping out_ready off the in_ready path.
            logic                 skid_valid;
            logic [PAYLOAD_W-1:0] skid_payload;
            logic [CTRL_W-1:0]    skid_ctrl;
            logic                 ready_q;

            // Head/skid update: skid drains to head on release, new entries
            // go to head when it is free or leaving, otherwise into skid.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    head_valid   <= 1'b0;
                    head_payload <= '0;
                    head_ctrl    <= '0;
                    skid_valid   <= 1'b0;
                    skid_payload <= '0;
                    skid_ctrl    <= '0;
                    ready_q      <= 1'b1;
                end else if (flush) begin
                    head_valid <= 1'b0;
                    skid_valid <= 1'b0;
                    ready_q    <= 1'b1;
                end else if (skid_valid) begin
                    if (out_ready) begin
                        head_payload <= skid_payload;
                        head_ctrl    <= skid_ctrl;
                        skid_valid   <= 1'b0;
                        ready_q      <= 1'b1;
                    end
                end else if (in_valid && ready_q) begin
                    if (!head_valid || out_ready) begin
                        head_valid   <= 1'b1;
                        head_payload <= in_payload;
                        head_ctrl    <= in_ctrl;
                    end else begin
                        skid_valid   <= 1'b1;
                        skid_payload <= in_payload;
                        skid_ctrl    <= in_ctrl;
                        ready_q      <= 1'b0;
                    end
                end else if (out_ready) begin
                    head_valid <= 1'b0;
                end
            end

            assign in_ready = ready_q;
            assign count    = {1'b0, head_valid} + {1'b0, skid_valid};
        end else begin : g_reg
            // Single entry: load on accept (which also covers replace on a
            // simultaneous release), otherwise empty on release.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    head_valid   <= 1'b0;
                    head_payload <= '0;
                    head_ctrl    <= '0;
                end else if (flush) begin
                    head_valid <= 1'b0;
                end else if (in_valid && in_ready) begin
                    head_valid   <= 1'b1;
                    head_payload <= in_payload;
                    head_ctrl    <= in_ctrl;
                end else if (out_ready) begin
                    head_valid <= 1'b0;
                end
            end

            assign in_ready = out_ready || !head_valid;
            assign count    = {1'b0, head_valid};
        end
    endgenerate

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Testbench for pipe_skid_reg: directed scenarios on the SKID=1 instance,
// a directed ready-path check on the SKID=0 instance, and a random
// valid/ready run against a queue scoreboard for both instances.
module tb_pipe_skid_reg;

    localparam int PW = 101;
    localparam int CW = 7;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic [PW-1:0] in_payload;
    logic [CW-1:0] in_ctrl;
    logic          out_ready;

    logic          rdy1, vld1, rdy0, vld0;
    logic [PW-1:0] pay1, pay0;
    logic [CW-1:0] ctl1, ctl0;
    logic [1:0]    cnt1, cnt0;

    // sel picks which instance the checks observe (1 = SKID=1)
    logic          sel;
    logic          c_rdy, c_vld;
    logic [PW-1:0] c_pay;
    logic [CW-1:0] c_ctl;
    logic [1:0]    c_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_skid_reg #(.PAYLOAD_W(PW), .CTRL_W(CW), .SKID(1)) u_dut1 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy1), .in_payload(in_payload), .in_ctrl(in_ctrl),
        .out_valid(vld1), .out_ready(out_ready), .out_payload(pay1), .out_ctrl(ctl1),
        .count(cnt1));

    pipe_skid_reg #(.PAYLOAD_W(PW), .CTRL_W(CW), .SKID(0)) u_dut0 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy0), .in_payload(in_payload), .in_ctrl(in_ctrl),
        .out_valid(vld0), .out_ready(out_ready), .out_payload(pay0), .out_ctrl(ctl0),
        .count(cnt0));

    assign c_rdy = sel ? rdy1 : rdy0;
    assign c_vld = sel ? vld1 : vld0;
    assign c_pay = sel ? pay1 : pay0;
    assign c_ctl = sel ? ctl1 : ctl0;
    assign c_cnt = sel ? cnt1 : cnt0;

    task automatic do_reset();
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_payload = '0;
        in_ctrl   = '0;
        out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        in_payload = PW'(5); in_ctrl = 7'h7F;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (vld1 !== 1'b0) begin n_fail++; $display("FAIL reset_vld1 got %b want 0", vld1); end
        n_checks++; if (pay1 !== '0) begin n_fail++; $display("FAIL reset_pay1 got %h want 0", pay1); end
        n_checks++; if (ctl1 !== '0) begin n_fail++; $display("FAIL reset_ctl1 got %h want 0", ctl1); end
        n_checks++; if (cnt1 !== 2'd0) begin n_fail++; $display("FAIL reset_cnt1 got %0d want 0", cnt1); end
        n_checks++; if (rdy1 !== 1'b1) begin n_fail++; $display("FAIL reset_rdy1 got %b want 1", rdy1); end
        n_checks++; if (vld0 !== 1'b0) begin n_fail++; $display("FAIL reset_vld0 got %b want 0", vld0); end
        n_checks++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL reset_rdy0 got %b want 1", rdy0); end
        n_checks++; if (cnt0 !== 2'd0) begin n_fail++; $display("FAIL reset_cnt0 got %0d want 0", cnt0); end
        in_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (vld1 !== 1'b0 || rdy1 !== 1'b1) begin n_fail++; $display("FAIL reset_release got vld=%b rdy=%b want 0/1", vld1, rdy1); end
    endtask

    task automatic test_pass_through();
        sel = 1'b1;
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_payload = PW'(1); in_ctrl = 7'h11;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_checks++; if (c_vld !== 1'b1 || c_pay !== PW'(k) || c_ctl !== CW'(7'h10 + k))
                begin n_fail++; $display("FAIL pass_%0d got vld=%b pay=%h ctl=%h want 1/%0d/%h", k, c_vld, c_pay, c_ctl, k, 7'h10 + k); end
            n_checks++; if (c_cnt !== 2'd1 || c_rdy !== 1'b1)
                begin n_fail++; $display("FAIL pass_cnt_%0d got cnt=%0d rdy=%b want 1/1", k, c_cnt, c_rdy); end
            in_payload = PW'(k + 1); in_ctrl = CW'(7'h11 + k);
            if (k == 3) in_valid = 1'b0;
        end
        @(negedge clk);
        n_checks++; if (c_vld !== 1'b0 || c_ctl !== '0 || c_cnt !== 2'd0 || c_pay !== PW'(3))
            begin n_fail++; $display("FAIL pass_drain got vld=%b ctl=%h cnt=%0d pay=%h want 0/0/0/3", c_vld, c_ctl, c_cnt, c_pay); end
    endtask

    task automatic test_backpressure();
        sel = 1'b1;
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_payload = PW'(16'hAAAA); in_ctrl = 7'h0A;
        @(negedge clk);
        n_checks++; if (c_cnt !== 2'd1 || c_rdy !== 1'b1 || c_pay !== PW'(16'hAAAA))
            begin n_fail++; $display("FAIL bp_a got cnt=%0d rdy=%b pay=%h", c_cnt, c_rdy, c_pay); end
        in_payload = PW'(16'hBBBB); in_ctrl = 7'h0B;
        @(negedge clk);
        n_checks++; if (c_cnt !== 2'd2 || c_rdy !== 1'b0 || c_pay !== PW'(16'hAAAA) || c_ctl !== 7'h0A)
            begin n_fail++; $display("FAIL bp_full got cnt=%0d rdy=%b pay=%h ctl=%h want 2/0/aaaa/0a", c_cnt, c_rdy, c_pay, c_ctl); end
        in_payload = PW'(16'hDDDD); in_ctrl = 7'h0D;
        @(negedge clk);
        n_checks++; if (c_cnt !== 2'd2 || c_pay !== PW'(16'hAAAA) || c_rdy !== 1'b0)
            begin n_fail++; $display("FAIL bp_hold got cnt=%0d pay=%h rdy=%b want 2/aaaa/0", c_cnt, c_pay, c_rdy); end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (c_vld !== 1'b1 || c_pay !== PW'(16'hBBBB) || c_ctl !== 7'h0B || c_cnt !== 2'd1 || c_rdy !== 1'b1)
            begin n_fail++; $display("FAIL bp_b got vld=%b pay=%h ctl=%h cnt=%0d rdy=%b want 1/bbbb/0b/1/1", c_vld, c_pay, c_ctl, c_cnt, c_rdy); end
        @(negedge clk);
        n_checks++; if (c_vld !== 1'b0 || c_cnt !== 2'd0)
            begin n_fail++; $display("FAIL bp_drain got vld=%b cnt=%0d want 0/0", c_vld, c_cnt); end
    endtask

    task automatic test_bubble();
        sel = 1'b1;
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b0; in_ctrl = 7'h7F; in_payload = PW'(9);
        @(negedge clk);
        n_checks++; if (c_vld !== 1'b0 || c_ctl !== '0)
            begin n_fail++; $display("FAIL bubble got vld=%b ctl=%h want 0/00", c_vld, c_ctl); end
        n_checks++; if (vld0 !== 1'b0 || ctl0 !== '0)
            begin n_fail++; $display("FAIL bubble0 got vld=%b ctl=%h want 0/00", vld0, ctl0); end
    endtask

    task automatic test_flush();
        sel = 1'b1;
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_payload = PW'(16'h1A1A); in_ctrl = 7'h21;
        @(negedge clk);
        in_payload = PW'(16'h1B1B); in_ctrl = 7'h22;
        @(negedge clk);
        n_checks++; if (c_cnt !== 2'd2)
            begin n_fail++; $display("FAIL flush_pre got cnt=%0d want 2", c_cnt); end
        flush = 1'b1; in_payload = PW'(16'hCCCC); in_ctrl = 7'h7F;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        n_checks++; if (c_vld !== 1'b0 || c_ctl !== '0 || c_cnt !== 2'd0 || c_rdy !== 1'b1)
            begin n_fail++; $display("FAIL flush got vld=%b ctl=%h cnt=%0d rdy=%b want 0/0/0/1", c_vld, c_ctl, c_cnt, c_rdy); end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++; if (c_vld !== 1'b0 || c_pay === PW'(16'hCCCC))
                begin n_fail++; $display("FAIL flush_after_%0d got vld=%b pay=%h want 0/not cccc", k, c_vld, c_pay); end
        end
    endtask

    task automatic test_async_reset();
        sel = 1'b1;
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_payload = PW'(16'h5A5A); in_ctrl = 7'h33;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (cnt1 !== 2'd1 || cnt0 !== 2'd1)
            begin n_fail++; $display("FAIL areset_pre got cnt1=%0d cnt0=%0d want 1/1", cnt1, cnt0); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (vld1 !== 1'b0 || pay1 !== '0 || cnt1 !== 2'd0 || ctl1 !== '0)
            begin n_fail++; $display("FAIL areset1 got vld=%b pay=%h cnt=%0d ctl=%h want all 0", vld1, pay1, cnt1, ctl1); end
        n_checks++; if (vld0 !== 1'b0 || pay0 !== '0 || cnt0 !== 2'd0)
            begin n_fail++; $display("FAIL areset0 got vld=%b pay=%h cnt=%0d want all 0", vld0, pay0, cnt0); end
        reset = 1'b0;
    endtask

    task automatic test_skid0_ready();
        sel = 1'b0;
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_payload = PW'(16'h00A0); in_ctrl = 7'h41;
        @(negedge clk);
        in_payload = PW'(16'h00B0); in_ctrl = 7'h42;
        #1;
        n_checks++; if (c_rdy !== 1'b0 || c_cnt !== 2'd1 || c_pay !== PW'(16'h00A0))
            begin n_fail++; $display("FAIL s0_stall got rdy=%b cnt=%0d pay=%h want 0/1/a0", c_rdy, c_cnt, c_pay); end
        @(negedge clk);
        n_checks++; if (c_cnt !== 2'd1 || c_pay !== PW'(16'h00A0))
            begin n_fail++; $display("FAIL s0_hold got cnt=%0d pay=%h want 1/a0", c_cnt, c_pay); end
        out_ready = 1'b1;
        #1;
        n_checks++; if (c_rdy !== 1'b1)
            begin n_fail++; $display("FAIL s0_comb_ready got %b want 1", c_rdy); end
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (c_cnt !== 2'd1 || c_pay !== PW'(16'h00B0) || c_ctl !== 7'h42)
            begin n_fail++; $display("FAIL s0_replace got cnt=%0d pay=%h ctl=%h want 1/b0/42", c_cnt, c_pay, c_ctl); end
        @(negedge clk);
        n_checks++; if (c_cnt !== 2'd0 || c_vld !== 1'b0)
            begin n_fail++; $display("FAIL s0_drain got cnt=%0d vld=%b want 0/0", c_cnt, c_vld); end
    endtask

    task automatic test_random(input logic s, input int ncyc);
        logic [PW-1:0] qp[$];
        logic [CW-1:0] qc[$];
        logic [127:0]  r;
        logic          prev_held;
        logic [PW-1:0] hp;
        logic [CW-1:0] hc;
        logic          acc, rel, exp_rdy;
        sel = s;
        do_reset();
        prev_held = 1'b0;
        hp = '0;
        hc = '0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            r = {$urandom, $urandom, $urandom, $urandom};
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 2) != 0);
            in_payload = r[PW-1:0];
            in_ctrl    = CW'($urandom_range(0, 127));
            #1;
            n_checks++; if (c_cnt !== 2'(qp.size()))
                begin n_fail++; $display("FAIL rnd%0d_cnt cyc %0d got %0d want %0d", s, c, c_cnt, qp.size()); end
            if (qp.size() > 0) begin
                n_checks++; if (c_vld !== 1'b1 || c_pay !== qp[0] || c_ctl !== qc[0])
                    begin n_fail++; $display("FAIL rnd%0d_head cyc %0d got vld=%b pay=%h ctl=%h want 1/%h/%h", s, c, c_vld, c_pay, c_ctl, qp[0], qc[0]); end
            end else begin
                n_checks++; if (c_vld !== 1'b0 || c_ctl !== '0)
                    begin n_fail++; $display("FAIL rnd%0d_empty cyc %0d got vld=%b ctl=%h want 0/0", s, c, c_vld, c_ctl); end
            end
            if (prev_held) begin
                n_checks++; if (c_pay !== hp || c_ctl !== hc)
                    begin n_fail++; $display("FAIL rnd%0d_stable cyc %0d got pay=%h ctl=%h want %h/%h", s, c, c_pay, c_ctl, hp, hc); end
            end
            exp_rdy = s ? (qp.size() < 2) : (out_ready || qp.size() == 0);
            n_checks++; if (c_rdy !== exp_rdy)
                begin n_fail++; $display("FAIL rnd%0d_ready cyc %0d got %b want %b", s, c, c_rdy, exp_rdy); end
            acc = in_valid && exp_rdy;
            rel = (qp.size() > 0) && out_ready;
            prev_held = (qp.size() > 0) && !out_ready;
            hp = c_pay;
            hc = c_ctl;
            if (rel) begin
                void'(qp.pop_front());
                void'(qc.pop_front());
            end
            if (acc) begin
                qp.push_back(in_payload);
                qc.push_back(in_ctrl);
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        sel = 1'b1;
        test_reset();
        test_pass_through();
        test_backpressure();
        test_bubble();
        test_flush();
        test_async_reset();
        test_skid0_ready();
        test_random(1'b1, 10000);
        test_random(1'b0, 10000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
